apb_req_master: RTL
===================

APB_REQ_MASTER -- requirements
Module: apb_req_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12: width of PADDR and addr_i.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, range 0..255: maximum ACCESS wait cycles; 0 disables the timeout.
REQ-003 SHALL have port HCLK  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_i  input  1  core request valid.
REQ-006 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr_i  input  APB_ADDR_WIDTH  byte address.
REQ-008 SHALL have port wdata_i  input  32  write data.
REQ-009 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-010 SHALL have port rvalid_o  output  1  one-cycle response strobe.
REQ-011 SHALL have port rdata_o  output  32  read data, valid with rvalid_o.
REQ-012 SHALL have port err_o  output  1  slave error or timeout, valid with rvalid_o.
REQ-013 SHALL have port busy_o  output  1  high in SETUP or ACCESS.
REQ-014 SHALL have ports PADDR out APB_ADDR_WIDTH, PWDATA out 32, PWRITE out 1, PSEL out 1, PENABLE out 1: APB3 requester outputs.
REQ-015 SHALL have ports PRDATA in 32, PREADY in 1, PSLVERR in 1: APB3 completer responses.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-017 gnt_o SHALL equal req_i AND (state == IDLE), combinationally.
REQ-018 On gnt_o, SHALL register addr_i, we_i, and wdata_i (wdata forced to 0 when we_i = 0), then go IDLE -> SETUP.
REQ-019 SETUP: PSEL = 1, PENABLE = 0; unconditional transition to ACCESS next cycle.
REQ-020 ACCESS: PSEL = 1, PENABLE = 1; stay in ACCESS while PREADY = 0.
REQ-021 PADDR, PWRITE, and PWDATA SHALL come from the registered values and stay stable from SETUP through the last ACCESS cycle.
REQ-022 When PREADY = 1 in ACCESS, SHALL go to IDLE and, in the next cycle, assert rvalid_o for exactly 1 cycle with:
- err_o = registered PSLVERR;
- rdata_o = registered PRDATA for reads, 0 for writes.
REQ-023 In IDLE, PSEL and PENABLE SHALL be 0; PADDR, PWRITE, and PWDATA SHALL hold their last values.
REQ-024 Back-to-back: a request SHALL be grantable in the same cycle rvalid_o is high, giving 3 cycles per zero-wait transfer.
REQ-025 Wait counter, 8 bits:
- cleared on entry to ACCESS;
- increments each ACCESS cycle with PREADY = 0;
- saturates at 255.
REQ-026 Timeout: if TIMEOUT_CYCLES != 0, PREADY = 0, and counter == TIMEOUT_CYCLES - 1 in ACCESS, SHALL go to IDLE (PSEL dropped next cycle) and then pulse rvalid_o with err_o = 1, rdata_o = 0.
REQ-027 PREADY = 1 in the same cycle the timeout condition is met SHALL take priority, completing normally.
REQ-028 PREADY and PSLVERR SHALL be ignored outside ACCESS.
REQ-029 rdata_o and err_o SHALL hold their values between rvalid_o strobes.
REQ-030 busy_o SHALL be 1 exactly when state is SETUP or ACCESS.
REQ-031 req_i changes while busy_o = 1 SHALL have no effect.

Reset
REQ-032 HRESETn low SHALL asynchronously force:
- state IDLE, wait counter 0;
- PSEL, PENABLE, PWRITE, rvalid_o, err_o = 0;
- PADDR, PWDATA, rdata_o = 0.
REQ-033 Reset asserted mid-transfer SHALL abort with no rvalid_o pulse; the first cycle after deassertion SHALL accept a new request.

Verification
REQ-034 Write 0xDEADBEEF to 0x008, PREADY = 1 always -> gnt in cycle 0, SETUP in cycle 1, ACCESS in cycle 2 with PADDR = 0x008, PWRITE = 1, PWDATA = 0xDEADBEEF; rvalid = 1, err = 0, rdata = 0 in cycle 3.
REQ-035 Read 0x010, PREADY low for 3 ACCESS cycles, PRDATA = 0x12345678 -> ACCESS lasts 4 cycles with PADDR stable; then rvalid with rdata = 0x12345678.
REQ-036 Read with PSLVERR = 1 at PREADY -> rvalid with err = 1; then a follow-up write granted in the rvalid cycle completes with err = 0.
REQ-037 TIMEOUT_CYCLES = 4, PREADY tied 0 -> PSEL high for 5 cycles (1 SETUP + 4 ACCESS), then rvalid with err = 1, rdata = 0; busy_o = 0.
REQ-038 TIMEOUT_CYCLES = 0, PREADY low for 300 cycles then high -> no timeout; normal completion after 301 ACCESS cycles.
REQ-039 HRESETn pulsed low in ACCESS -> PSEL = 0 and PENABLE = 0 immediately, no rvalid; a new read granted after release completes normally.

Source files
------------

// File: rtl/apb_req_master.sv
// apb_req_master: bridges a single-request core port onto an APB3 requester.
// One transfer runs at a time: IDLE -> SETUP -> ACCESS (waits on PREADY) -> IDLE.
// The response is a one-cycle rvalid_o strobe in the cycle after completion.
// An optional wait-state timeout ends a stuck transfer with err_o = 1.
//
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   req_i/we_i/addr_i/     core request; accepted when gnt_o is high
//   wdata_i, gnt_o
//   rvalid_o/rdata_o/err_o response strobe, read data, error (held between strobes)
//   busy_o                 transfer in SETUP or ACCESS
//   PADDR/PWDATA/PWRITE/   APB3 requester outputs
//   PSEL/PENABLE
//   PRDATA/PREADY/PSLVERR  APB3 completer inputs, sampled only in ACCESS
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic                      busy_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [31:0]               wdata;
  } req_t;

  localparam bit       TO_EN   = (TIMEOUT_CYCLES != 0);
  // Counter value seen in the last allowed wait cycle.
  localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

  state_t     state, state_nxt;
  req_t       req_q;
  logic [7:0] wait_cnt;
  logic       done_ok, done_to;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gnt_o     = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        gnt_o = req_i;
        if (req_i) state_nxt = SETUP;
      end
      SETUP: begin
        PSEL      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        // PREADY wins over a coincident timeout.
        done_ok = PREADY;
        done_to = !PREADY && TO_EN && (wait_cnt == TO_LAST);
        if (done_ok || done_to) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = PSEL;
  assign PADDR  = req_q.addr;
  assign PWRITE = req_q.we;
  assign PWDATA = req_q.wdata;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      req_q    <= '0;
      wait_cnt <= 8'd0;
      rvalid_o <= 1'b0;
      rdata_o  <= 32'd0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      if (gnt_o) begin
        req_q.addr  <= addr_i;
        req_q.we    <= we_i;
        req_q.wdata <= we_i ? wdata_i : 32'd0;
      end
      if (state == SETUP)
        wait_cnt <= 8'd0;
      else if (state == ACCESS && !PREADY && wait_cnt != 8'hFF)
        wait_cnt <= wait_cnt + 8'd1;
      if (done_ok) begin
        rvalid_o <= 1'b1;
        err_o    <= PSLVERR;
        rdata_o  <= req_q.we ? 32'd0 : PRDATA;
      end else if (done_to) begin
        rvalid_o <= 1'b1;
        err_o    <= 1'b1;
        rdata_o  <= 32'd0;
      end
    end
  end

endmodule
